// File: rtl/kw_ram_nra_1ws_dff.sv
// Flip-flop RAM: one byte-enabled synchronous write port, NUM_RD independent read ports.
// Reads are combinational or registered, with optional write-to-read bypass.
module kw_ram_nra_1ws_dff #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned REG_OUT    = 1,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned RESET_MODE = 1,
    localparam int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cs_n,
    input  logic                         we_n,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] data_out,
    output logic [NUM_RD-1:0]            rd_valid
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] dout [NUM_RD];
    logic                  vld  [NUM_RD];

    assign wr_fire = ~cs_n & ~we_n & (32'(wr_addr) < DEPTH);

    // Old word with enabled bytes replaced; feeds both the array and the bypass path.
    always_comb begin
        wr_word = mem_q[wr_addr];
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (wr_be[b]) begin
                wr_word[8*b +: 8] = data_in[8*b +: 8];
            end
        end
    end

    if (RESET_MODE != 0) begin : g_mem_rst
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int unsigned w = 0; w < DEPTH; w++) begin
                    mem_q[w] <= '0;
                end
            end else if (wr_fire) begin
                mem_q[wr_addr] <= wr_word;
            end
        end
    end else begin : g_mem_norst
        always_ff @(posedge clock) begin
            if (wr_fire) begin
                mem_q[wr_addr] <= wr_word;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  fire;
        logic                  hit;
        logic [DATA_WIDTH-1:0] rdata;

        assign ra   = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign fire = rd_en[i] & ~cs_n;
        assign hit  = (BYPASS != 0) && wr_fire && (ra == wr_addr);

        always_comb begin
            rdata = '0;
            if (32'(ra) < DEPTH) begin
                rdata = hit ? wr_word : mem_q[ra];
            end
        end

        if (REG_OUT != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  vld_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= fire;
                    if (fire) begin
                        dout_q <= rdata;
                    end
                end
            end

            assign dout[i] = dout_q;
            assign vld[i]  = vld_q;
        end else begin : g_comb
            assign dout[i] = fire ? rdata : '0;
            assign vld[i]  = fire;
        end
    end

    always_comb begin
        data_out = '0;
        rd_valid = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            data_out[i*DATA_WIDTH +: DATA_WIDTH] = dout[i];
            rd_valid[i]                          = vld[i];
        end
    end

endmodule

// File: tb/tb_kw_ram_nra_1ws_dff.sv
// Bench for kw_ram_nra_1ws_dff: a registered/bypass instance and a combinational/no-bypass
// instance share stimulus and are checked against an array reference model.
module tb_kw_ram_nra_1ws_dff;

    localparam int DW = 32;
    localparam int DP = 20;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cs_n = 1'b1;
    logic          we_n = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_be = '0;
    logic [DW-1:0] data_in = '0;
    logic [NR-1:0] rd_en = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] data_out_a, data_out_b;
    logic [NR-1:0]    rd_valid_a, rd_valid_b;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] ref_mem [DP];
    logic [DW-1:0] exp_d [NR];
    logic          exp_v [NR];

    always #5 clock = ~clock;

    kw_ram_nra_1ws_dff #(
        .DATA_WIDTH(DW), .DEPTH(DP), .NUM_RD(NR), .REG_OUT(1), .BYPASS(1), .RESET_MODE(1)
    ) u_a (
        .clock(clock), .reset(reset), .cs_n(cs_n), .we_n(we_n), .wr_addr(wr_addr),
        .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .data_out(data_out_a), .rd_valid(rd_valid_a)
    );

    kw_ram_nra_1ws_dff #(
        .DATA_WIDTH(DW), .DEPTH(DP), .NUM_RD(NR), .REG_OUT(0), .BYPASS(0), .RESET_MODE(1)
    ) u_b (
        .clock(clock), .reset(reset), .cs_n(cs_n), .we_n(we_n), .wr_addr(wr_addr),
        .wr_be(wr_be), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .data_out(data_out_b), .rd_valid(rd_valid_b)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [3:0] be,
                                            input logic [DW-1:0] nw);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic clear_model();
        for (int w = 0; w < DP; w++) ref_mem[w] = '0;
        for (int i = 0; i < NR; i++) begin
            exp_d[i] = '0;
            exp_v[i] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs (called just after a falling edge), check the
    // combinational instance before the edge and the registered one after it.
    task automatic cyc(input logic cs, input logic we, input int wa, input logic [3:0] be,
                       input logic [DW-1:0] din, input logic [NR-1:0] ren,
                       input int ra0, input int ra1);
        int  ra [NR];
        bit  wr;
        logic [DW-1:0] word;
        cs_n = cs; we_n = we; wr_addr = AW'(wa); wr_be = be; data_in = din; rd_en = ren;
        rd_addr = {AW'(ra1), AW'(ra0)};
        ra[0] = ra0; ra[1] = ra1;
        wr = !cs && !we && wa < DP;
        #1;
        for (int i = 0; i < NR; i++) begin
            bit fire;
            fire = ren[i] && !cs;
            word = (ra[i] < DP) ? ref_mem[ra[i]] : '0;
            check($sformatf("comb_data%0d", i), data_out_b[i*DW +: DW], fire ? word : '0);
            check($sformatf("comb_vld%0d", i), DW'(rd_valid_b[i]), DW'(fire));
            if (fire) begin
                exp_d[i] = (wr && ra[i] == wa) ? merge(word, be, din) : word;
            end
            exp_v[i] = fire;
        end
        if (wr) ref_mem[wa] = merge(ref_mem[wa], be, din);
        @(posedge clock);
        #1;
        for (int i = 0; i < NR; i++) begin
            check($sformatf("reg_data%0d", i), data_out_a[i*DW +: DW], exp_d[i]);
            check($sformatf("reg_vld%0d", i), DW'(rd_valid_a[i]), DW'(exp_v[i]));
        end
        @(negedge clock);
    endtask

    initial begin
        clear_model();
        #1;
        check("rst_data_a", data_out_a[DW-1:0], '0);
        check("rst_vld_a", DW'(rd_valid_a), '0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Full write then read-back latency, valid pulse and hold.
        cyc(0, 0, 3, 4'hF, 32'hA5A5_A5A5, 2'b00, 0, 0);
        cyc(0, 1, 0, 4'h0, '0, 2'b11, 3, 4);
        cyc(0, 1, 0, 4'h0, '0, 2'b00, 0, 0);
        for (int a = 0; a < DP; a += 2) cyc(0, 1, 0, 4'h0, '0, 2'b11, a, a + 1);

        // Byte-enabled partial write.
        cyc(0, 0, 5, 4'hF, 32'hFFFF_FFFF, 2'b00, 0, 0);
        cyc(0, 0, 5, 4'h1, 32'h0000_0000, 2'b00, 0, 0);
        cyc(0, 1, 0, 4'h0, '0, 2'b01, 5, 0);

        // Same-cycle collision with both ports reading the written address.
        cyc(0, 0, 7, 4'hF, 32'h1111_1111, 2'b00, 0, 0);
        cyc(0, 0, 7, 4'hF, 32'h2222_2222, 2'b11, 7, 7);
        cyc(0, 1, 0, 4'h0, '0, 2'b11, 7, 7);

        // Out-of-range write/read around the last word.
        cyc(0, 0, 19, 4'hF, 32'h1234_5678, 2'b00, 0, 0);
        cyc(0, 0, 25, 4'hF, 32'hDEAD_BEEF, 2'b00, 0, 0);
        cyc(0, 1, 0, 4'h0, '0, 2'b11, 25, 19);
        cyc(0, 0, 20, 4'hF, 32'hCAFE_F00D, 2'b11, 20, 19);

        // All-zero byte enables, then deselected write/read.
        cyc(0, 0, 19, 4'h0, 32'h0BAD_0BAD, 2'b10, 0, 19);
        cyc(1, 0, 19, 4'hF, 32'h5555_5555, 2'b11, 19, 19);
        cyc(0, 1, 0, 4'h0, '0, 2'b11, 19, 3);

        // Randomized traffic, addresses spanning the out-of-range region.
        for (int n = 0; n < 300; n++) begin
            cyc(($urandom % 8) == 0, $urandom % 2, $urandom % 24, 4'($urandom), $urandom,
                2'($urandom), $urandom % 24, $urandom % 24);
        end

        // Asynchronous reset between edges while every port keeps reading.
        cyc(0, 0, 9, 4'hF, 32'h9999_9999, 2'b11, 9, 3);
        cyc(0, 1, 0, 4'h0, '0, 2'b11, 9, 3);
        #2;
        reset = 1'b1;
        #1;
        clear_model();
        check("arst_data_a", data_out_a[DW-1:0], '0);
        check("arst_data_a1", data_out_a[2*DW-1:DW], '0);
        check("arst_vld_a", DW'(rd_valid_a), '0);
        check("arst_mem_b", data_out_b[DW-1:0], '0);
        #1;
        reset = 1'b0;
        @(negedge clock);
        cyc(0, 0, 9, 4'hF, 32'h7777_7777, 2'b11, 9, 3);
        cyc(0, 1, 0, 4'h0, '0, 2'b11, 9, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
